// File: rtl/tap_trig_disc_pkg.sv
// TAP ctl bus field map (cmd_defs definitions) and trigger FSM state type.
// Fields: THR [13:0], GT 14, ET 15, LT 16, TRIG_EN 17.
`ifndef TAP_CMD_DEFS_VH
`define TAP_CMD_DEFS_VH
`define N_TAP_CTL_SIZE      18
`define CTL_TAP_THR         13:0
`define CTL_TAP_GT          14
`define CTL_TAP_ET          15
`define CTL_TAP_LT          16
`define CTL_TAP_TRIG_EN     17
`define TAP_ADC_W           14
`define TAP_TRIG_S_DISARMED 2'd0
`define TAP_TRIG_S_ARMED    2'd1
`define TAP_TRIG_S_HOLDOFF  2'd2
`endif

package tap_trig_disc_pkg;
  localparam int TAP_CTL_W = `N_TAP_CTL_SIZE;

  typedef enum logic [1:0] {
    S_DISARMED = `TAP_TRIG_S_DISARMED,
    S_ARMED    = `TAP_TRIG_S_ARMED,
    S_HOLDOFF  = `TAP_TRIG_S_HOLDOFF
  } trig_state_e;
endpackage

// File: rtl/tap_trig_disc_cmp.sv
// Registered threshold comparator: one result per valid sample, plus previous result and delayed valid.
// force_set re-seeds both results to 1 so only a fresh false->true transition can produce an edge.
module tap_thr_cmp #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] data,
  input  logic         valid,
  input  logic [W-1:0] thr,
  input  logic         gt,
  input  logic         et,
  input  logic         lt,
  input  logic         force_set,
  output logic         cond_q,
  output logic         cond_prev,
  output logic         v1
);
  logic cmp;
  logic cond_d;
  logic cond_prev_d, cond_prev_q;
  logic v1_d, v1_q;

  always_comb begin
    cmp         = (gt && (data > thr)) || (et && (data == thr)) || (lt && (data < thr));
    cond_d      = cond_q;
    cond_prev_d = cond_prev_q;
    v1_d        = valid;
    // Re-arm seeding wins over a sample landing on the same edge
    if (force_set) begin
      cond_d      = 1'b1;
      cond_prev_d = 1'b1;
    end else if (valid) begin
      cond_d      = cmp;
      cond_prev_d = cond_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond_q      <= 1'b1;
      cond_prev_q <= 1'b1;
      v1_q        <= 1'b0;
    end else begin
      cond_q      <= cond_d;
      cond_prev_q <= cond_prev_d;
      v1_q        <= v1_d;
    end
  end

  assign cond_prev = cond_prev_q;
  assign v1        = v1_q;
endmodule

// File: rtl/tap_trig_disc.sv
// ADC threshold trigger discriminator with holdoff; trig pulses 2 clks after the edge-making sample.
// Optional TAP_TRIG_TS_EN adds a free-running timestamp latched on each trigger (trig_ts/trig_ts_vld).
module tap_trig_disc
  import tap_trig_disc_pkg::*;
#(
  parameter int ADC_W   = `TAP_ADC_W,
  parameter int HOLDOFF = 16,
  parameter int CNT_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [`N_TAP_CTL_SIZE-1:0] ctl,
  input  logic [ADC_W-1:0]           adc_data,
  input  logic                       adc_valid,
  output logic                       trig,
  output logic [CNT_W-1:0]           trig_cnt,
  output logic                       armed
`ifdef TAP_TRIG_TS_EN
  ,
  output logic [CNT_W-1:0]           trig_ts,
  output logic                       trig_ts_vld
`endif
);
  localparam int HW = $clog2(HOLDOFF + 1);

  trig_state_e       state_d, state_q;
  logic [HW-1:0]     hold_cnt_d, hold_cnt_q;
  logic [CNT_W-1:0]  trig_cnt_d, trig_cnt_q;
  logic              trig_d, trig_q;
  logic              armed_d, armed_q;
  logic              force_set;
  logic              cond_q, cond_prev, v1;
  logic              edge_det;
  logic              trig_en;

  assign trig_en = ctl[`CTL_TAP_TRIG_EN];

  tap_thr_cmp #(.W(ADC_W)) u_cmp (
    .clk       (clk),
    .rst_n     (rst_n),
    .data      (adc_data),
    .valid     (adc_valid),
    .thr       (ctl[`CTL_TAP_THR]),
    .gt        (ctl[`CTL_TAP_GT]),
    .et        (ctl[`CTL_TAP_ET]),
    .lt        (ctl[`CTL_TAP_LT]),
    .force_set (force_set),
    .cond_q    (cond_q),
    .cond_prev (cond_prev),
    .v1        (v1)
  );

  assign edge_det = cond_q && !cond_prev && v1;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    trig_cnt_d = trig_cnt_q;
    trig_d     = 1'b0;
    force_set  = 1'b0;
    case (state_q)
      S_DISARMED: begin
        if (trig_en) begin
          state_d   = S_ARMED;
          force_set = 1'b1;
        end
      end
      S_ARMED: begin
        // Disarm outranks a coincident edge: no pulse, no count
        if (!trig_en) begin
          state_d = S_DISARMED;
        end else if (edge_det) begin
          trig_d     = 1'b1;
          trig_cnt_d = trig_cnt_q + CNT_W'(1);
          hold_cnt_d = HW'(HOLDOFF - 1);
          state_d    = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (!trig_en) begin
          state_d    = S_DISARMED;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == '0) begin
          state_d   = S_ARMED;
          force_set = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q - HW'(1);
        end
      end
      default: state_d = S_DISARMED;
    endcase
    armed_d = (state_d == S_ARMED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_DISARMED;
      hold_cnt_q <= '0;
      trig_cnt_q <= '0;
      trig_q     <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      trig_cnt_q <= trig_cnt_d;
      trig_q     <= trig_d;
      armed_q    <= armed_d;
    end
  end

  assign trig     = trig_q;
  assign trig_cnt = trig_cnt_q;
  assign armed    = armed_q;

`ifdef TAP_TRIG_TS_EN
  logic [CNT_W-1:0] ts_cnt_d, ts_cnt_q;
  logic [CNT_W-1:0] trig_ts_d, trig_ts_q;
  logic             trig_ts_vld_d, trig_ts_vld_q;

  always_comb begin
    ts_cnt_d      = ts_cnt_q + CNT_W'(1);
    trig_ts_d     = trig_d ? ts_cnt_q : trig_ts_q;
    trig_ts_vld_d = trig_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt_q      <= '0;
      trig_ts_q     <= '0;
      trig_ts_vld_q <= 1'b0;
    end else begin
      ts_cnt_q      <= ts_cnt_d;
      trig_ts_q     <= trig_ts_d;
      trig_ts_vld_q <= trig_ts_vld_d;
    end
  end

  assign trig_ts     = trig_ts_q;
  assign trig_ts_vld = trig_ts_vld_q;
`endif
endmodule

// File: tb/tb_tap_trig_disc.sv
// Directed-vector bench for tap_trig_disc; cycle numbers count clocks since reset release.
module tb_tap_trig_disc;
  localparam int CNT_W = 32;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [`N_TAP_CTL_SIZE-1:0] ctl;
  logic [13:0]                adc_data;
  logic                       adc_valid;
  logic                       trig;
  logic [CNT_W-1:0]           trig_cnt;
  logic                       armed;
`ifdef TAP_TRIG_TS_EN
  logic [CNT_W-1:0]           trig_ts;
  logic                       trig_ts_vld;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   trig_n = 0;
  int   trig_at [4];
  logic trig_prev = 1'b0;

  always #5 clk = ~clk;

  tap_trig_disc #(.ADC_W(14), .HOLDOFF(16), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ctl         (ctl),
    .adc_data    (adc_data),
    .adc_valid   (adc_valid),
    .trig        (trig),
    .trig_cnt    (trig_cnt),
    .armed       (armed)
`ifdef TAP_TRIG_TS_EN
    ,
    .trig_ts     (trig_ts),
    .trig_ts_vld (trig_ts_vld)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ctl(input logic en, input logic gt, input logic et, input logic lt,
                         input logic [13:0] thr);
    ctl                   = '0;
    ctl[`CTL_TAP_THR]     = thr;
    ctl[`CTL_TAP_GT]      = gt;
    ctl[`CTL_TAP_ET]      = et;
    ctl[`CTL_TAP_LT]      = lt;
    ctl[`CTL_TAP_TRIG_EN] = en;
  endtask

  // Apply one cycle of ADC input, then observe outputs 1 time unit after the edge
  task automatic step(input logic [13:0] d, input logic v);
    adc_data  = d;
    adc_valid = v;
    @(posedge clk);
    #1;
    cyc++;
    if (trig === 1'b1) begin
      chk("trig_one_clk", trig_prev, 0);
      if (trig_n < 4) trig_at[trig_n] = cyc;
      trig_n++;
    end
    trig_prev = trig;
  endtask

  task automatic do_reset();
    adc_valid = 1'b0;
    adc_data  = '0;
    ctl       = '0;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    cyc       = 0;
    trig_n    = 0;
    trig_prev = 1'b0;
    for (int i = 0; i < 4; i++) trig_at[i] = -1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_trig", trig, 0);
    chk("rst_cnt", trig_cnt, 0);
    chk("rst_armed", armed, 0);

    // GT 1000: 900,1001,1200 -> single trig two clks after 1001 (sampled in cycle 2)
    set_ctl(1, 1, 0, 0, 1000);
    step(0, 0);
    chk("t1_armed", armed, 1);
    step(900, 1);
    step(1001, 1);
    step(1200, 1);
    repeat (4) step(0, 0);
    chk("t1_n", trig_n, 1);
    chk("t1_at", trig_at[0], 4);
    chk("t1_cnt", trig_cnt, 1);

    // Square wave 0/2000, period 8: edges land at cycles 6,14,22,30; holdoff covers 7..22
    do_reset();
    set_ctl(1, 1, 0, 0, 1000);
    step(0, 0);
    for (int k = 0; k < 36; k++) step(((k / 4) % 2) ? 14'd2000 : 14'd0, 1);
    repeat (2) step(0, 0);
    chk("t2_n", trig_n, 2);
    chk("t2_at0", trig_at[0], 7);
    chk("t2_at1", trig_at[1], 31);
    chk("t2_cnt", trig_cnt, 2);

    // ET 500: 499 then 500
    do_reset();
    set_ctl(1, 0, 1, 0, 500);
    step(0, 0);
    step(499, 1);
    step(500, 1);
    repeat (3) step(0, 0);
    chk("t3_et_n", trig_n, 1);
    chk("t3_et_at", trig_at[0], 4);

    // LT 10: 20 then 5
    do_reset();
    set_ctl(1, 0, 0, 1, 10);
    step(0, 0);
    step(20, 1);
    step(5, 1);
    repeat (3) step(0, 0);
    chk("t3_lt_n", trig_n, 1);
    chk("t3_lt_at", trig_at[0], 4);

    // No mode bits: compare is always false
    do_reset();
    set_ctl(1, 0, 0, 0, 10);
    step(0, 0);
    step(20, 1); step(5, 1); step(20, 1); step(0, 1); step(10, 1); step(5, 1);
    repeat (3) step(0, 0);
    chk("t3_none_n", trig_n, 0);
    chk("t3_none_armed", armed, 1);

    // Already-true at arm time never triggers; dip and recover does (2000 sampled in cycle 9)
    do_reset();
    set_ctl(0, 1, 0, 0, 1000);
    repeat (3) step(2000, 1);
    chk("t4_disarmed", armed, 0);
    set_ctl(1, 1, 0, 0, 1000);
    repeat (5) step(2000, 1);
    chk("t4_hold_n", trig_n, 0);
    chk("t4_armed", armed, 1);
    step(0, 1);
    step(2000, 1);
    repeat (3) step(0, 0);
    chk("t4_n", trig_n, 1);
    chk("t4_at", trig_at[0], 11);
    chk("t4_cnt", trig_cnt, 1);

    // Disarm in the very cycle the edge is seen
    do_reset();
    set_ctl(1, 1, 0, 0, 1000);
    step(0, 0);
    step(0, 1);
    step(2000, 1);
    set_ctl(0, 1, 0, 0, 1000);
    step(0, 0);
    chk("t5_trig", trig, 0);
    chk("t5_armed", armed, 0);
    chk("t5_cnt", trig_cnt, 0);
    repeat (3) step(0, 0);
    chk("t5_n", trig_n, 0);

    // Asynchronous reset while trig is high at the start of holdoff
    do_reset();
    set_ctl(1, 1, 0, 0, 1000);
    step(0, 0);
    step(0, 1);
    step(2000, 1);
    step(0, 0);
    chk("t5_pre_trig", trig, 1);
    chk("t5_pre_cnt", trig_cnt, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_arst_trig", trig, 0);
    chk("t5_arst_cnt", trig_cnt, 0);
    chk("t5_arst_armed", armed, 0);

    // Counter wraps from all-ones to zero
    do_reset();
    set_ctl(1, 1, 0, 0, 1000);
    step(0, 0);
    force dut.trig_cnt_q = {CNT_W{1'b1}};
    step(0, 1);
    release dut.trig_cnt_q;
    chk("wrap_pre", trig_cnt, 64'hFFFF_FFFF);
    step(2000, 1);
    step(0, 0);
    chk("wrap_trig", trig, 1);
    chk("wrap_cnt", trig_cnt, 0);

`ifdef TAP_TRIG_TS_EN
    // Trigger decided at timestamp 37 (2000 sampled in cycle 36)
    do_reset();
    set_ctl(1, 1, 0, 0, 1000);
    step(0, 0);
    while (cyc < 36) step(0, 1);
    step(2000, 1);
    step(0, 0);
    chk("ts_trig", trig, 1);
    chk("ts_vld", trig_ts_vld, 1);
    chk("ts_val", trig_ts, 37);
    step(0, 0);
    chk("ts_vld_drop", trig_ts_vld, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
